vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the video scanout reader and the 68k CPU bus.
- Video reads have absolute priority and fixed latency, so scanout never glitches.
- CPU 16-bit word accesses are split into big-endian byte cycles issued in slots the video port leaves free.
- CPU completion uses a DTACK-style level acknowledge.

Parameters:
AW, 15, RAM byte address width
DW, 8, RAM data width (fixed at 8; CPU side is 2*DW)

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-high reset
vid_rd  in  1  video read strobe, one RAM slot per cycle high
vid_addr  in  AW  video byte address, valid with vid_rd
vid_dout  out  DW  video read data (registered)
vid_valid  out  1  vid_dout valid strobe
cpu_req  in  1  CPU cycle request (level, held until cpu_ack)
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  AW-1  CPU word address
cpu_uds  in  1  upper byte (even address) select
cpu_lds  in  1  lower byte (odd address) select
cpu_din  in  2*DW  CPU write data; [15:8] upper, [7:0] lower
cpu_dout  out  2*DW  CPU read data, stable while cpu_ack
cpu_ack  out  1  level acknowledge
ram_addr  out  AW  RAM address (combinational from slot owner)
ram_we  out  1  RAM write enable
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data, valid the cycle after the address

Behaviour:
- Reset values: vid_dout=0, vid_valid=0, cpu_dout=0, cpu_ack=0, FSM=IDLE, capture flags clear.
- During reset and in idle slots: ram_we=0, ram_addr=0, ram_din=0.
- Slot rule, per cycle:
  - If vid_rd=1, the video port owns the slot: ram_addr=vid_addr, ram_we=0.
  - Otherwise, the slot goes to the CPU if the FSM is in HI or LO; else the slot is idle.
- Video latency: vid_rd high in cycle N -> vid_valid high for exactly one cycle in N+2, vid_dout = RAM[vid_addr]. Back-to-back vid_rd is allowed on every cycle, fully pipelined.
- CPU FSM states: IDLE, HI, LO, FIN, DONE.
  - IDLE: on cpu_req=1 -> HI if uds; else LO if lds; else DONE. On entry, cpu_dout is cleared to 0.
  - HI: byte address {cpu_addr,0}; write data cpu_din[15:8]. Advances only on a granted slot (vid_rd=0), then -> LO if lds, else FIN.
  - LO: byte address {cpu_addr,1}; write data cpu_din[7:0]. Advances on a granted slot, then -> FIN.
  - FIN: one cycle so the last read byte is captured -> DONE.
  - DONE: cpu_ack=1, cpu_dout held. Leaves to IDLE when cpu_req=0; cpu_ack drops in the cycle after cpu_req is seen low.
- Read capture:
  - A granted CPU read slot in cycle N loads ram_dout in cycle N+1 into cpu_dout[15:8] (HI) or cpu_dout[7:0] (LO).
  - Unselected bytes read as 0.
- Writes: ram_we=1 only in the granted CPU slot cycle; one byte per slot.
- Stall: while vid_rd=1 the CPU FSM holds its state. There is no starvation limit; scanout gaps guarantee progress.
- Simultaneous events:
  - vid_rd and a CPU slot in the same cycle: video wins, the CPU byte is retried next cycle.
  - A video capture and a CPU capture never coincide, because slots are exclusive.
- cpu_req dropping before ack (bus error/abort):
  - The in-flight byte completes.
  - The FSM then returns to IDLE via FIN/DONE without asserting cpu_ack if cpu_req is already low at DONE entry.
- Reset mid-operation: asynchronous return to IDLE and all outputs to reset values. Any partial word write is not rolled back.

Test Plan:
- Video read stream: RAM[0x0100..0x0103]=11,22,33,44 and vid_rd high 4 cycles from addr 0x0100 -> vid_valid pulses in cycles N+2..N+5 with vid_dout=11,22,33,44, and ram_we stays 0.
- CPU word write, no contention: cpu_addr=0x0080, uds=lds=1, din=0xBEEF -> RAM[0x0100]=BE and RAM[0x0101]=EF in consecutive cycles; cpu_ack rises in the 4th cycle after cpu_req and falls one cycle after cpu_req drops.
- CPU word read with contention: vid_rd high in alternate cycles, CPU reads addr 0x0080 -> cpu_dout=0xBEEF at ack; video data is uncorrupted and arrives with 2-cycle latency throughout.
- Byte strobes:
  - lds-only write 0x12AB to 0x0081 -> only RAM[0x0103]=AB is written.
  - uds-only read -> cpu_dout[7:0]=0.
  - Neither strobe -> ack within 2 cycles, no RAM access.
- Full stall: vid_rd held high 50 cycles during a CPU request -> no CPU RAM access and ack=0 throughout; the CPU completes within 4 cycles after vid_rd drops.
- Async reset asserted while in LO state -> ack=0, vid_valid=0, ram_we=0 immediately; a new CPU request after reset completes normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous video RAM between the scanout reader and the 68k CPU.
// Video reads always win the slot; CPU words are issued as big-endian byte cycles in free slots.
module vram_arbiter #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              vid_rd_i,
    input  logic [AW-1:0]     vid_addr_i,
    output logic [DW-1:0]     vid_dout_o,
    output logic              vid_valid_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [AW-2:0]     cpu_addr_i,
    input  logic              cpu_uds_i,
    input  logic              cpu_lds_i,
    input  logic [2*DW-1:0]   cpu_din_i,
    output logic [2*DW-1:0]   cpu_dout_o,
    output logic              cpu_ack_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic              ram_we_o,
    output logic [DW-1:0]     ram_din_o,
    input  logic [DW-1:0]     ram_dout_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_FIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic            cap_hi_q, cap_hi_d;
    logic            cap_lo_q, cap_lo_d;
    logic [2*DW-1:0] cpu_dout_q, cpu_dout_d;

    logic            vid_pend_q;
    logic            vid_valid_q;
    logic [DW-1:0]   vid_dout_q;

    // Slot owner mux: video first, then the CPU byte phase, otherwise an idle slot.
    always_comb begin
        ram_addr_o = '0;
        ram_we_o   = 1'b0;
        ram_din_o  = '0;
        if (!reset_i) begin
            if (vid_rd_i) begin
                ram_addr_o = vid_addr_i;
            end else if (state_q == S_HI) begin
                ram_addr_o = {cpu_addr_i, 1'b0};
                ram_we_o   = cpu_we_i;
                ram_din_o  = cpu_din_i[2*DW-1:DW];
            end else if (state_q == S_LO) begin
                ram_addr_o = {cpu_addr_i, 1'b1};
                ram_we_o   = cpu_we_i;
                ram_din_o  = cpu_din_i[DW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        cap_hi_d   = 1'b0;
        cap_lo_d   = 1'b0;
        cpu_dout_d = cpu_dout_q;

        if (cap_hi_q) begin
            cpu_dout_d[2*DW-1:DW] = ram_dout_i;
        end
        if (cap_lo_q) begin
            cpu_dout_d[DW-1:0] = ram_dout_i;
        end

        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (cpu_req_i) begin
                    cpu_dout_d = '0;
                    if (cpu_uds_i) begin
                        state_d = S_HI;
                    end else if (cpu_lds_i) begin
                        state_d = S_LO;
                    end else begin
                        state_d = S_DONE;
                        ack_d   = 1'b1;
                    end
                end
            end
            // An aborted request still finishes the byte in flight but skips the low byte.
            S_HI: begin
                if (!vid_rd_i) begin
                    cap_hi_d = !cpu_we_i;
                    state_d  = (cpu_lds_i && cpu_req_i) ? S_LO : S_FIN;
                end
            end
            S_LO: begin
                if (!vid_rd_i) begin
                    cap_lo_d = !cpu_we_i;
                    state_d  = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_DONE;
                ack_d   = cpu_req_i;
            end
            S_DONE: begin
                if (!cpu_req_i) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            cap_hi_q   <= 1'b0;
            cap_lo_q   <= 1'b0;
            cpu_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            cap_hi_q   <= cap_hi_d;
            cap_lo_q   <= cap_lo_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Two-stage video pipe: address cycle, RAM output cycle, then registered data.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vid_pend_q  <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_dout_q  <= '0;
        end else begin
            vid_pend_q  <= vid_rd_i;
            vid_valid_q <= vid_pend_q;
            if (vid_pend_q) begin
                vid_dout_q <= ram_dout_i;
            end
        end
    end

    assign vid_dout_o  = vid_dout_q;
    assign vid_valid_o = vid_valid_q;
    assign cpu_dout_o  = cpu_dout_q;
    assign cpu_ack_o   = ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, video scoreboard, table of CPU transactions
// and hand-written contention, stall, abort and reset sequences.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            vidRd;
    logic [AW-1:0]   vidAddr;
    logic [DW-1:0]   vidDout;
    logic            vidValid;
    logic            cpuReq;
    logic            cpuWe;
    logic [AW-2:0]   cpuAddr;
    logic            cpuUds;
    logic            cpuLds;
    logic [15:0]     cpuDin;
    logic [15:0]     cpuDout;
    logic            cpuAck;
    logic [AW-1:0]   ramAddr;
    logic            ramWe;
    logic [DW-1:0]   ramDin;
    logic [DW-1:0]   ramDout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wrCount = 0;

    logic [7:0] mem    [0:32767];
    logic [7:0] shadow [0:32767];

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } vexp_t;
    vexp_t vq[$];

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic        uds;
        logic        lds;
        logic [15:0] din;
        logic [15:0] expDout;
        int          expLat;
        int          expWrites;
    } vec_t;
    vec_t vecs[9];

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .vid_rd_i   (vidRd),
        .vid_addr_i (vidAddr),
        .vid_dout_o (vidDout),
        .vid_valid_o(vidValid),
        .cpu_req_i  (cpuReq),
        .cpu_we_i   (cpuWe),
        .cpu_addr_i (cpuAddr),
        .cpu_uds_i  (cpuUds),
        .cpu_lds_i  (cpuLds),
        .cpu_din_i  (cpuDin),
        .cpu_dout_o (cpuDout),
        .cpu_ack_o  (cpuAck),
        .ram_addr_o (ramAddr),
        .ram_we_o   (ramWe),
        .ram_din_o  (ramDin),
        .ram_dout_i (ramDout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] initVal(input int a);
        logic [7:0] v;
        case (a)
            'h100:   v = 8'h11;
            'h101:   v = 8'h22;
            'h102:   v = 8'h33;
            'h103:   v = 8'h44;
            default: v = 8'(a) ^ 8'h5A;
        endcase
        return v;
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after the address.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = initVal(i);
        forever begin
            @(posedge clk);
            if (ramWe) begin
                mem[ramAddr] <= ramDin;
                wrCount++;
            end
            ramDout <= mem[ramAddr];
        end
    end

    // Video scoreboard and slot-ownership monitor.
    always @(negedge clk) begin
        vexp_t e;
        if (!reset) begin
            if (vidRd) begin
                tests++;
                if (ramWe || ramAddr != vidAddr) begin
                    fails++;
                    $display("[TB] FAIL video slot: ram_addr=%h ram_we=%b, required %h / 0", ramAddr, ramWe, vidAddr);
                end
            end
            if (vidValid) begin
                tests++;
                if (vq.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL video unexpected valid: data=%h cycle %0d", vidDout, cyc);
                end else begin
                    e = vq.pop_front();
                    if (vidDout != e.data || cyc != e.cyc) begin
                        fails++;
                        $display("[TB] FAIL video data: got %h at cycle %0d, required %h at cycle %0d", vidDout, cyc, e.data, e.cyc);
                    end
                end
            end else if (vq.size() > 0 && vq[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("[TB] FAIL video missing valid: required %h at cycle %0d", vq[0].data, vq[0].cyc);
                void'(vq.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic vidDrive(input logic en, input logic [AW-1:0] addr, input logic [7:0] data);
        vidRd   = en;
        vidAddr = addr;
        if (en) vq.push_back('{data: data, cyc: cyc + 2});
    endtask

    // mode 0: no video, 1: video every other cycle, 2: video held for the first 50 cycles.
    task automatic applyStimulus(input vec_t v, input int mode, input logic [AW-1:0] vidBase,
                                 output logic [15:0] dout, output int lat, output int nWr,
                                 output bit stallOk);
        int  start;
        int  startWr;
        bit  got;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        cpuWe = v.we; cpuAddr = v.addr; cpuUds = v.uds; cpuLds = v.lds; cpuDin = v.din;
        cpuReq = 1'b1;
        start = cyc; startWr = wrCount; got = 0; stallOk = 1; dout = '0; lat = -1;
        for (int i = 0; i < 200; i++) begin
            a = vidBase + AW'(i);
            if (mode == 1)      vidDrive(i % 2 == 0, a, initVal(int'(a)));
            else if (mode == 2) vidDrive(i < 50, a, initVal(int'(a)));
            else                vidRd = 1'b0;
            @(negedge clk);
            if (mode == 2 && i < 50 && (cpuAck || wrCount != startWr)) stallOk = 0;
            if (cpuAck) begin
                got = 1; lat = cyc - start; dout = cpuDout;
                break;
            end
            @(posedge clk); #1;
        end
        nWr = wrCount - startWr;
        if (!got) begin
            tests++; fails++;
            $display("[TB] FAIL ack timeout: no ack within 200 cycles for addr %h", v.addr);
        end
        @(posedge clk); #1;
        vidRd = 1'b0; cpuReq = 1'b0;
        @(negedge clk);
        checkOutput("ack held while req drops", cpuAck, got);
        checkOutput("dout stable during ack", cpuDout, dout);
        @(negedge clk);
        checkOutput("ack drop", cpuAck, 0);
    endtask

    initial begin
        logic [15:0] dout;
        int lat, nWr;
        bit ok;
        bit abortOk;
        int wr0;
        for (int i = 0; i < 32768; i++) shadow[i] = initVal(i);

        vecs[0] = '{1'b1, 14'h0080, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 4, 2};
        vecs[1] = '{1'b0, 14'h0080, 1'b1, 1'b1, 16'h0000, 16'hBEEF, 4, 0};
        vecs[2] = '{1'b1, 14'h0081, 1'b0, 1'b1, 16'h12AB, 16'h0000, 3, 1};
        vecs[3] = '{1'b0, 14'h0081, 1'b1, 1'b1, 16'h0000, 16'h33AB, 4, 0};
        vecs[4] = '{1'b0, 14'h0080, 1'b1, 1'b0, 16'h0000, 16'hBE00, 3, 0};
        vecs[5] = '{1'b0, 14'h0081, 1'b0, 1'b1, 16'h0000, 16'h00AB, 3, 0};
        vecs[6] = '{1'b1, 14'h0090, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1, 0};
        vecs[7] = '{1'b1, 14'h0090, 1'b1, 1'b0, 16'h7700, 16'h0000, 3, 1};
        vecs[8] = '{1'b0, 14'h0090, 1'b1, 1'b1, 16'h0000, 16'h777B, 4, 0};

        reset = 1'b1; cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuUds = 0; cpuLds = 0; cpuDin = '0;
        vidRd = 1'b1; vidAddr = 15'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset vid_valid", vidValid, 0);
        checkOutput("reset vid_dout", vidDout, 0);
        checkOutput("reset cpu_ack", cpuAck, 0);
        checkOutput("reset cpu_dout", cpuDout, 0);
        checkOutput("reset ram_addr", ramAddr, 0);
        checkOutput("reset ram_we", ramWe, 0);
        vidRd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] video read stream");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            vidDrive(1'b1, AW'(15'h100 + k), initVal('h100 + k));
        end
        @(posedge clk); #1;
        vidRd = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("stream drained", vq.size(), 0);
        checkOutput("stream no writes", wrCount, 0);

        $display("[TB] CPU transaction table");
        for (int n = 0; n < 9; n++) begin
            applyStimulus(vecs[n], 0, '0, dout, lat, nWr, ok);
            checkOutput($sformatf("vec%0d dout", n), dout, vecs[n].expDout);
            checkOutput($sformatf("vec%0d ack latency", n), lat, vecs[n].expLat);
            checkOutput($sformatf("vec%0d write count", n), nWr, vecs[n].expWrites);
            if (vecs[n].we) begin
                if (vecs[n].uds) shadow[{vecs[n].addr, 1'b0}] = vecs[n].din[15:8];
                if (vecs[n].lds) shadow[{vecs[n].addr, 1'b1}] = vecs[n].din[7:0];
                checkOutput($sformatf("vec%0d ram hi", n), mem[{vecs[n].addr, 1'b0}], shadow[{vecs[n].addr, 1'b0}]);
                checkOutput($sformatf("vec%0d ram lo", n), mem[{vecs[n].addr, 1'b1}], shadow[{vecs[n].addr, 1'b1}]);
            end
        end

        $display("[TB] CPU read under alternating video");
        applyStimulus(vecs[1], 1, 15'h200, dout, lat, nWr, ok);
        checkOutput("contended read dout", dout, 16'hBEEF);
        checkOutput("contended read writes", nWr, 0);

        $display("[TB] CPU write under full video stall");
        applyStimulus('{1'b1, 14'h00A0, 1'b1, 1'b1, 16'h5566, 16'h0000, 0, 0}, 2, 15'h200, dout, lat, nWr, ok);
        checkOutput("stall no access or ack", ok, 1);
        checkOutput("stall ack latency", lat, 53);
        checkOutput("stall ram hi", mem[15'h140], 8'h55);
        checkOutput("stall ram lo", mem[15'h141], 8'h66);

        $display("[TB] CPU abort before ack");
        @(posedge clk); #1;
        cpuWe = 1; cpuAddr = 14'h00C0; cpuUds = 1; cpuLds = 1; cpuDin = 16'hC3C4; cpuReq = 1;
        wr0 = wrCount;
        abortOk = 1;
        @(posedge clk); #1;
        cpuReq = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpuAck) abortOk = 0;
        end
        checkOutput("abort no ack", abortOk, 1);
        checkOutput("abort in-flight byte", mem[15'h180], 8'hC3);
        checkOutput("abort single write", wrCount - wr0, 1);

        $display("[TB] reset in LO state");
        @(posedge clk); #1;
        cpuWe = 1; cpuAddr = 14'h00B0; cpuUds = 1; cpuLds = 1; cpuDin = 16'h9988; cpuReq = 1;
        vidDrive(1'b1, 15'h220, initVal('h220));
        @(posedge clk); #1;
        vidDrive(1'b1, 15'h221, initVal('h221));
        @(posedge clk); #1;
        vidRd = 1'b0;
        @(posedge clk); #1;
        checkOutput("LO write slot before reset", ramWe, 1);
        checkOutput("video valid before reset", vidValid, 1);
        vq.delete();
        reset = 1'b1;
        #1;
        checkOutput("async reset ack", cpuAck, 0);
        checkOutput("async reset vid_valid", vidValid, 0);
        checkOutput("async reset ram_we", ramWe, 0);
        checkOutput("async reset cpu_dout", cpuDout, 0);
        cpuReq = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("partial write kept", mem[15'h160], 8'h99);
        applyStimulus('{1'b0, 14'h00A0, 1'b1, 1'b1, 16'h0000, 16'h5566, 4, 0}, 0, '0, dout, lat, nWr, ok);
        checkOutput("post-reset read dout", dout, 16'h5566);
        checkOutput("post-reset read latency", lat, 4);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", vq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
